// File: rtl/rsa_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_job_ctrl
// Brief    : Host-side job initiator for the RSA_PBL modular-exponentiation
//            core: word-stream operand load, core launch, result word drain.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_job_ctrl #(
    parameter int DW      = 256,
    parameter int BW      = 32,
    parameter int NW      = DW / BW,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_word,
    output logic          out_last,
    output logic          core_rstn,
    output logic [31:0]   core_mp,
    output logic [31:0]   core_pow,
    output logic [DW-1:0] core_modulos,
    output logic [DW-1:0] core_indata,
    input  logic [DW-1:0] core_outdata,
    input  logic          core_end,
    output logic          busy,
    output logic          err_timeout
);

    localparam int IW  = $clog2(2 * NW + 2);
    localparam int CW  = $clog2(RST_CYC + 1);
    localparam int NCW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [IW-1:0]  c_LAST_IDX  = IW'(2 * NW + 1);
    localparam logic [CW-1:0]  c_RST_LAST  = CW'(RST_CYC - 1);
    localparam logic [15:0]    c_TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [NCW-1:0] c_LAST_WORD = NCW'(NW - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_idx;
    logic [CW-1:0]  r_cyc;
    logic [15:0]    r_run_cnt;
    logic [DW-1:0]  r_shift;
    logic [NCW-1:0] r_cnt;

    logic w_accept;
    logic w_capture;
    logic w_timeout;
    logic w_out_hs;

    assign w_accept  = in_valid && (r_state == S_LOAD);
    // The core may still be presenting end_flag from a previous run while
    // it comes out of reset, so the first RUN cycle never captures.
    assign w_capture = (r_state == S_RUN) && core_end && (r_run_cnt != 16'd0);
    assign w_timeout = (r_state == S_RUN) && !w_capture && (r_run_cnt == c_TO_LAST);
    assign w_out_hs  = (r_state == S_DRAIN) && out_ready;
    assign out_word  = r_shift[BW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        core_rstn   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept && (r_idx == c_LAST_IDX)) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cyc == c_RST_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                core_rstn = 1'b1;
                if (w_capture) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DRAIN: begin
                core_rstn = 1'b1;
                out_valid = 1'b1;
                out_last  = (r_cnt == c_LAST_WORD);
                if (out_ready && (r_cnt == c_LAST_WORD)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_cyc        <= '0;
            r_run_cnt    <= '0;
            r_shift      <= '0;
            r_cnt        <= '0;
            core_mp      <= '0;
            core_pow     <= '0;
            core_modulos <= '0;
            core_indata  <= '0;
            err_timeout  <= 1'b0;
        end else begin
            // Word 0 = mp, 1 = pow, then modulos and indata LS word first.
            if (w_accept) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
                if (r_idx == '0) begin
                    core_mp <= 32'(in_word);
                end
                if (r_idx == IW'(1)) begin
                    core_pow <= 32'(in_word);
                end
                for (int i = 0; i < NW; i++) begin
                    if (r_idx == IW'(2 + i)) begin
                        core_modulos[i*BW +: BW] <= in_word;
                    end
                    if (r_idx == IW'(2 + NW + i)) begin
                        core_indata[i*BW +: BW] <= in_word;
                    end
                end
            end

            r_cyc     <= (r_state == S_START) ? r_cyc + 1'b1 : '0;
            r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;

            if (w_capture) begin
                r_shift <= core_outdata;
            end else if (w_out_hs) begin
                r_shift <= r_shift >> BW;
            end

            if (w_out_hs) begin
                r_cnt <= (r_cnt == c_LAST_WORD) ? '0 : r_cnt + 1'b1;
            end

            if (w_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_job_ctrl
// Brief    : Self-checking bench for rsa_job_ctrl with a behavioural RSA core
//            and a result-word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_job_ctrl;

    localparam int DW      = 256;
    localparam int BW      = 32;
    localparam int NW      = 8;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 100;
    localparam int END_DLY = 20;

    localparam logic [255:0] c_STALE = {8{32'hdeadbeef}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_word = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_word;
    logic          out_last;
    logic          core_rstn;
    logic [31:0]   core_mp;
    logic [31:0]   core_pow;
    logic [DW-1:0] core_modulos;
    logic [DW-1:0] core_indata;
    logic [DW-1:0] core_outdata = c_STALE;
    logic          core_end = 1'b0;
    logic          busy;
    logic          err_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pop    = 0;

    logic [32:0]  sb_q[$];
    logic [255:0] m_result = '0;
    int           m_delay  = 0;
    bit           m_stale  = 1'b0;
    int           run_cyc  = 0;
    bit           stall_en = 1'b0;
    bit           mon_en   = 1'b1;
    bit           idle_due = 1'b0;

    rsa_job_ctrl #(
        .DW(DW), .BW(BW), .NW(NW), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last),
        .core_rstn(core_rstn), .core_mp(core_mp), .core_pow(core_pow),
        .core_modulos(core_modulos), .core_indata(core_indata),
        .core_outdata(core_outdata), .core_end(core_end),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural core: end_flag m_delay cycles after release (0 = never).
    always @(posedge clk) begin
        if (!core_rstn) begin
            run_cyc      <= 0;
            core_end     <= m_stale;
            core_outdata <= c_STALE;
        end else begin
            run_cyc  <= run_cyc + 1;
            core_end <= (m_delay > 0) && (run_cyc + 1 == m_delay);
            if ((m_delay > 0) && (run_cyc + 1 == m_delay)) begin
                core_outdata <= m_result;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (idle_due) begin
                check_eq("idle_after_last", {busy, core_rstn}, 2'b00);
                idle_due = 1'b0;
            end
            if (out_valid) begin
                check_eq("in_ready_drain", in_ready, 1'b0);
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    check_eq("out_word", out_word, sb_q[0][31:0]);
                    check_eq("out_last", out_last, sb_q[0][32]);
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        n_pop++;
                        if (out_last) idle_due = 1'b1;
                    end
                end
            end
        end else begin
            idle_due = 1'b0;
        end
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Entered at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [31:0] w, input bit gaps);
        bit done = 1'b0;
        int guard = 0;
        while (!done) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_word  = w;
            @(negedge clk);
            done = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 200) begin
                check_eq("load_stuck_in_ready", in_ready, 1'b1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_ops(input string tag, input logic [31:0] mp, input logic [31:0] pw,
                             input logic [255:0] md, input logic [255:0] ind);
        check_eq({tag, "_mp"},  core_mp, mp);
        check_eq({tag, "_pow"}, core_pow, pw);
        check_eq({tag, "_mod"}, core_modulos, md);
        check_eq({tag, "_ind"}, core_indata, ind);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_handshake"}, {in_ready, out_valid, out_last}, 3'b100);
        check_eq({tag, "_out_word"}, out_word, 32'd0);
        check_eq({tag, "_ctl"}, {core_rstn, busy, err_timeout}, 3'b000);
        check_ops(tag, 32'd0, 32'd0, 256'd0, 256'd0);
    endtask

    task automatic start_job(input logic [31:0] mp, input logic [31:0] pw,
                             input logic [255:0] md, input logic [255:0] ind,
                             input logic [255:0] res, input int dly, input bit stale,
                             input bit gaps, input bit exp_out);
        m_result = res;
        m_delay  = dly;
        m_stale  = stale;
        n_pop    = 0;
        if (exp_out) begin
            for (int i = 0; i < NW; i++) sb_q.push_back({(i == NW - 1), res[i*32 +: 32]});
        end
        @(posedge clk);
        #1;
        send_word(mp, gaps);
        send_word(pw, gaps);
        for (int i = 0; i < NW; i++) send_word(md[i*32 +: 32], gaps);
        for (int i = 0; i < NW; i++) send_word(ind[i*32 +: 32], gaps);
        @(negedge clk);
        check_eq("rstn_start_c1", core_rstn, 1'b0);
        check_ops("loaded", mp, pw, md, ind);
        @(negedge clk);
        check_eq("rstn_start_c2", core_rstn, 1'b0);
        @(negedge clk);
        check_eq("rstn_release", core_rstn, 1'b1);
    endtask

    task automatic finish_job(input bit junk, input logic [31:0] mp, input logic [31:0] pw,
                              input logic [255:0] md, input logic [255:0] ind);
        int k = 0;
        if (junk) begin
            in_valid = 1'b1;
            in_word  = 32'hbad0bad0;
        end
        while (!out_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq("end_to_out_valid", k, END_DLY + 1);
        if (junk) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        k = 0;
        while ((busy || sb_q.size() != 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("drained", sb_q.size(), 0);
        check_eq("busy_low", busy, 1'b0);
        check_ops("held", mp, pw, md, ind);
    endtask

    initial begin
        logic [31:0]  mp, pw;
        logic [255:0] md, ind, res;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reference operands, no stalls
        mp  = 32'hd79435e5;
        pw  = 32'd3272068392;
        md  = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013;
        ind = 256'h1d33e562bfffffe98b58107fffffff931152ffffffffff0084ffffffffffff09;
        res = 256'h01234567_89abcdef_11223344_55667788_99aabbcc_ddeeff00_a5a5a5a5_5a5a5aef;
        start_job(mp, pw, md, ind, res, END_DLY, 1'b0, 1'b0, 1'b1);
        finish_job(1'b0, mp, pw, md, ind);

        // Stale end_flag present as the core comes out of reset
        mp = $urandom; pw = $urandom; md = rand256(); ind = rand256(); res = rand256();
        start_job(mp, pw, md, ind, res, END_DLY, 1'b1, 1'b0, 1'b1);
        finish_job(1'b0, mp, pw, md, ind);
        m_stale = 1'b0;

        // Input gaps, output stalls, ignored words while busy
        stall_en = 1'b1;
        for (int j = 0; j < 2; j++) begin
            mp = $urandom; pw = $urandom; md = rand256(); ind = rand256(); res = rand256();
            start_job(mp, pw, md, ind, res, END_DLY, 1'b0, 1'b1, 1'b1);
            finish_job(1'b1, mp, pw, md, ind);
        end

        // Core never finishes
        mp = $urandom; pw = $urandom; md = rand256(); ind = rand256();
        start_job(mp, pw, md, ind, 256'd0, 0, 1'b0, 1'b0, 1'b0);
        check_eq("err_before_timeout", err_timeout, 1'b0);
        n = 0;
        while (core_rstn && n < 300) begin
            n++;
            @(negedge clk);
        end
        check_eq("timeout_run_cycles", n, TIMEOUT);
        check_eq("timeout_state", {err_timeout, in_ready, out_valid, busy}, 4'b1100);

        mp = $urandom; pw = $urandom; md = rand256(); ind = rand256(); res = rand256();
        start_job(mp, pw, md, ind, res, END_DLY, 1'b0, 1'b1, 1'b1);
        finish_job(1'b0, mp, pw, md, ind);
        check_eq("err_sticky", err_timeout, 1'b1);

        // Reset after three result words
        mp = $urandom; pw = $urandom; md = rand256(); ind = rand256(); res = rand256();
        start_job(mp, pw, md, ind, res, END_DLY, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (n_pop < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("pops_before_rst", n_pop, 3);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_drain_rst");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        mp = $urandom; pw = $urandom; md = rand256(); ind = rand256(); res = rand256();
        start_job(mp, pw, md, ind, res, END_DLY, 1'b0, 1'b1, 1'b1);
        finish_job(1'b0, mp, pw, md, ind);
        check_eq("err_after_rst", err_timeout, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
